param_fifo: RTL

Parametrised synchronous FIFO; next generation of the fixed 32-bit queue used between pipeline stages.
- Generalises data width and depth.
- Adds a legal simultaneous read/write when full, almost-full/almost-empty thresholds, a synchronous flush, sticky overflow/underflow error flags and a read-valid strobe.
- Single clock domain; drop-in wherever the core buffers instructions, results or memory requests.

---
 rtl/param_fifo_pkg.sv | 13 +
 rtl/param_fifo_if.sv | 42 ++++
 rtl/param_fifo_mem_2p.sv | 29 ++
 rtl/param_fifo.sv | 114 +++++++++++
 4 files changed

// File: rtl/param_fifo_pkg.sv
// Shared constants and types for the parametrised FIFO.
// Default width/depth replace the old fixed buffer-width/size macros.
package param_fifo_pkg;

  localparam int DEFAULT_DATA_W     = 32;
  localparam int DEFAULT_DEPTH_LOG2 = 4;

  typedef struct packed {
    logic wr;
    logic rd;
  } fifo_acc_t;

endpackage

// File: rtl/param_fifo_if.sv
// Push/pop/status bundle for param_fifo; hwm exists only when QUEUE_HWM_EN is defined.
interface param_fifo_if
  import param_fifo_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
);
  logic                  flush;
  logic                  wr_en;
  logic [DATA_W-1:0]     buf_in;
  logic                  rd_en;
  logic [DATA_W-1:0]     buf_out;
  logic                  rd_valid;
  logic                  buf_empty;
  logic                  buf_full;
  logic                  almost_full;
  logic                  almost_empty;
  logic [DEPTH_LOG2:0]   fifo_counter;
  logic                  overflow;
  logic                  underflow;
`ifdef QUEUE_HWM_EN
  logic [DEPTH_LOG2:0]   hwm;
`endif

  modport master (
    output flush, wr_en, buf_in, rd_en,
    input  buf_out, rd_valid, buf_empty, buf_full, almost_full, almost_empty,
           fifo_counter, overflow, underflow
`ifdef QUEUE_HWM_EN
    , input hwm
`endif
  );

  modport slave (
    input  flush, wr_en, buf_in, rd_en,
    output buf_out, rd_valid, buf_empty, buf_full, almost_full, almost_empty,
           fifo_counter, overflow, underflow
`ifdef QUEUE_HWM_EN
    , output hwm
`endif
  );
endinterface

// File: rtl/param_fifo_mem_2p.sv
// DATA_W x 2**ADDR_W storage with one write port and a registered read port.
// rdata resets to zero and holds whenever re is low; the array itself is not reset.
module fifo_mem_2p #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata_q <= '0;
    else if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/param_fifo.sv
// Parametrised synchronous FIFO with thresholds, flush, sticky error flags and read-valid.
// Optional high-water-mark output enabled by defining QUEUE_HWM_EN.
module param_fifo
  import param_fifo_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2,
  parameter int AF_THRESH  = (1 << DEPTH_LOG2) - 1,
  parameter int AE_THRESH  = 1
) (
  input  logic          clk,
  input  logic          rst,
  param_fifo_if.slave   bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  ovf_q, ovf_d, unf_q, unf_d;
  logic                  empty, full;
  fifo_acc_t             acc;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  // A pop on a full FIFO frees the slot the simultaneous push needs; flush overrides both.
  always_comb begin
    acc.rd = bus.rd_en & ~empty & ~bus.flush;
    acc.wr = bus.wr_en & (~full | bus.rd_en) & ~bus.flush;
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_valid_d = 1'b0;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      if (acc.wr) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
      if (acc.rd) rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
      count_d    = count_q + CW'(acc.wr) - CW'(acc.rd);
      rd_valid_d = acc.rd;
      if (bus.wr_en & full & ~bus.rd_en) ovf_d = 1'b1;
      if (bus.rd_en & empty)             unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  fifo_mem_2p #(
    .DATA_W (DATA_W),
    .ADDR_W (DEPTH_LOG2)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (acc.wr),
    .waddr (wr_ptr_q),
    .wdata (bus.buf_in),
    .re    (acc.rd),
    .raddr (rd_ptr_q),
    .rdata (bus.buf_out)
  );

  assign bus.rd_valid     = rd_valid_q;
  assign bus.buf_empty    = empty;
  assign bus.buf_full     = full;
  assign bus.almost_full  = (count_q >= CW'(AF_THRESH));
  assign bus.almost_empty = (count_q <= CW'(AE_THRESH));
  assign bus.fifo_counter = count_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;

`ifdef QUEUE_HWM_EN
  logic [CW-1:0] hwm_q, hwm_d;

  always_comb begin
    hwm_d = hwm_q;
    if (bus.flush)            hwm_d = '0;
    else if (count_d > hwm_q) hwm_d = count_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hwm_q <= '0;
    else     hwm_q <= hwm_d;
  end

  assign bus.hwm = hwm_q;
`endif
endmodule
